cdb_arbiter_mc: RTL and testbench
=================================

// Module: cdb_arbiter_mc
// PURPOSE
//  Parametrised common-data-bus arbiter. It collects writeback requests from N_SRC
//  execution units and broadcasts up to N_CDB results per cycle on registered CDB lanes.
//  The lanes feed the reservation stations, the ROB and the register file.
//  Arbitration is round-robin, so no source can starve; a flush input squashes
//  broadcasts that would otherwise issue.
// PARAMETERS
//  N_SRC   3   number of requesting units; must be >= 2
//  N_CDB   1   number of broadcast lanes; 1 <= N_CDB <= N_SRC
//  TAG_W   4   ROB/physical tag width
//  DATA_W  32  result width
// PORTS
//  clk        in   1              clock, rising edge
//  rst_n      in   1              asynchronous reset, active-low
//  flush      in   1              squash: no grants this cycle, lanes idle next cycle
//  src_req    in   N_SRC          per-source result valid
//  src_tag    in   N_SRC*TAG_W    per-source tag; source i occupies bits [i*TAG_W +: TAG_W]
//  src_wdata  in   N_SRC*DATA_W   per-source result; packed like src_tag
//  src_rdy    out  N_SRC          grant; a transfer happens when src_req[i] && src_rdy[i]
//  cdb_wr     out  N_CDB          lane valid (registered)
//  cdb_tag    out  N_CDB*TAG_W    lane tag (registered)
//  cdb_wdata  out  N_CDB*DATA_W   lane data (registered)
//  rr_ptr_o   out  $clog2(N_SRC)  current highest-priority source, for debug/coverage
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous):
//    - cdb_wr, cdb_tag, cdb_wdata and rr_ptr all go to 0.
//    - src_rdy is 0 while reset is asserted.
//  - Grant selection (combinational, each cycle):
//    - Scan sources in order rr_ptr, rr_ptr+1, ... mod N_SRC.
//    - The first up-to-N_CDB sources with src_req=1 get src_rdy=1; all others get 0.
//    - src_rdy[i] is never 1 when src_req[i] is 0.
//    - A source must not make src_req depend on src_rdy, to avoid a combinational loop.
//  - Lane mapping: the k-th granted source in scan order drives lane k.
//    Lanes are filled from 0 upward with no gaps.
//  - Latency: one cycle. A grant in cycle t appears on cdb_* in cycle t+1.
//  - Lane output in the next cycle:
//    - Filled lane: cdb_wr=1, with that source's tag/wdata.
//    - Unfilled lane: cdb_wr=0, cdb_tag=0, cdb_wdata=0 (no stale data).
//  - Pointer update:
//    - At least one grant: rr_ptr <= (index of last granted source + 1) mod N_SRC.
//    - No grant: rr_ptr holds.
//    - Wrap from N_SRC-1 to 0.
//  - Source holding: a denied source keeps req/tag/wdata stable until granted.
//    The arbiter does not buffer requests.
//  - flush=1:
//    - All src_rdy forced to 0.
//    - Next-cycle cdb_wr=0 on every lane, tag/wdata=0.
//    - rr_ptr holds.
//    - flush has priority over any pending request.
//  - Fairness: with all N_SRC requesting continuously, every source is granted
//    at least once in any ceil(N_SRC/N_CDB) consecutive cycles.
//  - If rst_n asserts mid-broadcast, the lanes clear immediately. No partial broadcast
//    survives reset.
// CONFIGURATION
//  - CDB_RR_EN defined: round-robin as described above.
//  - CDB_RR_EN undefined: fixed priority (source 0 highest, then ascending index).
//    - rr_ptr is tied to 0 and rr_ptr_o reads 0.
//    - Starvation of high-index sources is then permitted.
// STRUCTURE
//  - cdb_pkg holds:
//    - cdb_lane_t struct {logic wr; logic [TAG_W-1:0] tag; logic [DATA_W-1:0] wdata;}
//    - default TAG_W/DATA_W localparams
//    - function cdb_wrap_inc(ptr, n)
//  - Sub-module cdb_rr_pick (combinational): inputs req vector, ptr and N_CDB; outputs
//    grant vector and per-lane source index plus lane-valid.
//    - Implementation: rotate by ptr, do iterative find-first N_CDB times, then rotate back.
//  - Top level holds the lane registers and the rr_ptr register.
// TESTING
//  1. Reset
//     - Stimulus: hold rst_n=0 with src_req=3'b111.
//     - Required: src_rdy=0, cdb_wr=0, cdb_tag=0.
//     - Release reset (N_SRC=3, N_CDB=1): src_rdy=3'b001, and next cycle cdb_wr=1 with
//       src0's tag.
//  2. Round-robin rotation
//     - Stimulus (N_SRC=3, N_CDB=1): src_req=3'b111 held for 6 cycles.
//     - Required: grants 0,1,2,0,1,2; rr_ptr_o sequence 0,1,2,0,1,2.
//  3. Multi-lane fill
//     - Stimulus (N_SRC=4, N_CDB=2): rr_ptr=3, src_req=4'b1011.
//     - Required: src_rdy=4'b1001; lane0 carries src3, lane1 carries src0; next rr_ptr=1.
//  4. Idle lane and hold
//     - Stimulus: src_req=0 for 2 cycles.
//     - Required: cdb_wr=0, tag=0, wdata=0 on all lanes; rr_ptr unchanged.
//  5. Flush
//     - Stimulus: flush=1 with src_req=3'b110.
//     - Required: src_rdy=0; next cycle cdb_wr=0; rr_ptr unchanged.
//     - After dropping flush, src1 is granted before src2.
//  6. Fixed-priority build (CDB_RR_EN undefined)
//     - Stimulus: src_req=3'b111 for 4 cycles.
//     - Required: src0 granted all 4 cycles; rr_ptr_o=0.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter.
package cdb_pkg;

  localparam int unsigned CDB_TAG_W  = 4;
  localparam int unsigned CDB_DATA_W = 32;

  typedef struct packed {
    logic                  wr;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] wdata;
  } cdb_lane_t;

  function automatic int unsigned cdb_wrap_inc(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational picker: grants up to N_CDB requesters scanning from ptr_i, and
// reports which source drives each lane (lanes filled from 0 with no gaps).
module cdb_rr_pick #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned N_CDB = 1,
  parameter int unsigned PW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0]          req_i,
  input  logic [PW-1:0]             ptr_i,
  output logic [N_SRC-1:0]          gnt_o,
  output logic [N_CDB-1:0][PW-1:0]  lane_src_o,
  output logic [N_CDB-1:0]          lane_vld_o
);

  // Rotated position j corresponds to source (j + ptr) mod N_SRC; ptr is always < N_SRC.
  function automatic int unsigned rot_idx(input int unsigned j, input int unsigned p);
    return (j + p >= N_SRC) ? j + p - N_SRC : j + p;
  endfunction

  logic [N_SRC-1:0] rot_req;
  logic [N_SRC-1:0] rot_gnt;
  logic [N_SRC-1:0] remain;

  always_comb begin
    rot_req    = '0;
    rot_gnt    = '0;
    remain     = '0;
    lane_vld_o = '0;
    lane_src_o = '0;
    gnt_o      = '0;
    for (int unsigned j = 0; j < N_SRC; j++) begin
      rot_req[j] = req_i[rot_idx(j, 32'(ptr_i))];
    end
    remain = rot_req;
    for (int unsigned k = 0; k < N_CDB; k++) begin
      for (int unsigned j = 0; j < N_SRC; j++) begin
        if (remain[j] && !lane_vld_o[k]) begin
          lane_vld_o[k] = 1'b1;
          lane_src_o[k] = PW'(rot_idx(j, 32'(ptr_i)));
          rot_gnt[j]    = 1'b1;
          remain[j]     = 1'b0;
        end
      end
    end
    for (int unsigned j = 0; j < N_SRC; j++) begin
      gnt_o[rot_idx(j, 32'(ptr_i))] = rot_gnt[j];
    end
  end

endmodule

// File: rtl/cdb_arbiter_mc.sv
// Common-data-bus arbiter with registered broadcast lanes. Define CDB_RR_EN for
// round-robin arbitration; otherwise fixed priority with source 0 highest.
module cdb_arbiter_mc
  import cdb_pkg::*;
#(
  parameter int unsigned N_SRC  = 3,
  parameter int unsigned N_CDB  = 1,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned DATA_W = CDB_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [N_SRC-1:0]           src_req,
  input  logic [N_SRC*TAG_W-1:0]     src_tag,
  input  logic [N_SRC*DATA_W-1:0]    src_wdata,
  output logic [N_SRC-1:0]           src_rdy,
  output logic [N_CDB-1:0]           cdb_wr,
  output logic [N_CDB*TAG_W-1:0]     cdb_tag,
  output logic [N_CDB*DATA_W-1:0]    cdb_wdata,
  output logic [$clog2(N_SRC)-1:0]   rr_ptr_o
);

  localparam int unsigned PW = $clog2(N_SRC);

  logic [N_SRC-1:0]          pick_gnt;
  logic [N_CDB-1:0][PW-1:0]  lane_src;
  logic [N_CDB-1:0]          lane_vld;

  logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [N_CDB-1:0]          wr_q, wr_d;
  logic [N_CDB*TAG_W-1:0]    tag_q, tag_d;
  logic [N_CDB*DATA_W-1:0]   wdata_q, wdata_d;

  cdb_rr_pick #(
    .N_SRC (N_SRC),
    .N_CDB (N_CDB),
    .PW    (PW)
  ) u_pick (
    .req_i      (src_req),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (pick_gnt),
    .lane_src_o (lane_src),
    .lane_vld_o (lane_vld)
  );

  assign src_rdy = (flush || !rst_n) ? '0 : pick_gnt;

  // Unfilled or flushed lanes load zeros so no stale payload is ever broadcast.
  always_comb begin
    wr_d    = '0;
    tag_d   = '0;
    wdata_d = '0;
    for (int unsigned k = 0; k < N_CDB; k++) begin
      if (lane_vld[k] && !flush) begin
        wr_d[k]                       = 1'b1;
        tag_d[k*TAG_W +: TAG_W]       = src_tag[32'(lane_src[k])*TAG_W +: TAG_W];
        wdata_d[k*DATA_W +: DATA_W]   = src_wdata[32'(lane_src[k])*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CDB_RR_EN
  // Highest filled lane holds the last granted source in scan order.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!flush) begin
      for (int unsigned k = 0; k < N_CDB; k++) begin
        if (lane_vld[k]) rr_ptr_d = PW'(cdb_wrap_inc(32'(lane_src[k]), N_SRC));
      end
    end
  end
`else
  assign rr_ptr_d = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      wr_q     <= '0;
      tag_q    <= '0;
      wdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      tag_q    <= tag_d;
      wdata_q  <= wdata_d;
    end
  end

  assign cdb_wr    = wr_q;
  assign cdb_tag   = tag_q;
  assign cdb_wdata = wdata_q;
  assign rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter_mc.sv
// Bench for cdb_arbiter_mc: a 3-source/1-lane and a 4-source/2-lane instance,
// checked against a reference pick model through an expected-lane scoreboard.
module tb_cdb_arbiter_mc;

  typedef struct {
    logic [1:0]  wr;
    logic [7:0]  tag;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]   a_req;
  logic         a_flush;
  logic [11:0]  a_tag;
  logic [95:0]  a_wdata;
  logic [2:0]   a_rdy;
  logic [0:0]   a_wr;
  logic [3:0]   a_ctag;
  logic [31:0]  a_cdata;
  logic [1:0]   a_ptr;

  logic [3:0]   b_req;
  logic         b_flush;
  logic [15:0]  b_tag;
  logic [127:0] b_wdata;
  logic [3:0]   b_rdy;
  logic [1:0]   b_wr;
  logic [7:0]   b_ctag;
  logic [63:0]  b_cdata;
  logic [1:0]   b_ptr;

  int total = 0;
  int bad   = 0;
  int ptr_a = 0;
  int ptr_b = 0;
  exp_t qa[$];
  exp_t qb[$];

  cdb_arbiter_mc #(.N_SRC(3), .N_CDB(1), .TAG_W(4), .DATA_W(32)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (a_flush),
    .src_req   (a_req),
    .src_tag   (a_tag),
    .src_wdata (a_wdata),
    .src_rdy   (a_rdy),
    .cdb_wr    (a_wr),
    .cdb_tag   (a_ctag),
    .cdb_wdata (a_cdata),
    .rr_ptr_o  (a_ptr)
  );

  cdb_arbiter_mc #(.N_SRC(4), .N_CDB(2), .TAG_W(4), .DATA_W(32)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (b_flush),
    .src_req   (b_req),
    .src_tag   (b_tag),
    .src_wdata (b_wdata),
    .src_rdy   (b_rdy),
    .cdb_wr    (b_wr),
    .cdb_tag   (b_ctag),
    .cdb_wdata (b_cdata),
    .rr_ptr_o  (b_ptr)
  );

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", nm, obs, exp);
    end
  endtask

  // Reference: scan from ptr, grant the first m requesters, pointer past the last grant.
  function automatic void model(input logic [3:0] req, input int ptr, input int n, input int m,
                                input logic fl, output logic [3:0] gnt, output int s0,
                                output int s1, output int cnt, output int nptr);
    gnt = '0; s0 = 0; s1 = 0; cnt = 0; nptr = ptr;
    if (!fl) begin
      for (int j = 0; j < n; j++) begin
        int i;
        i = (ptr + j) % n;
        if (req[i] && cnt < m) begin
          gnt[i] = 1'b1;
          if (cnt == 0) s0 = i;
          else s1 = i;
          cnt++;
          nptr = (i + 1) % n;
        end
      end
    end
  endfunction

  task automatic step_a(input logic [2:0] req, input logic fl);
    logic [3:0] g;
    int s0, s1, c, np;
    exp_t e;
    a_req = req;
    a_flush = fl;
    for (int i = 0; i < 3; i++) begin
      a_tag[i*4 +: 4]    = 4'($urandom);
      a_wdata[i*32 +: 32] = $urandom;
    end
    #1;
    model({1'b0, req}, ptr_a, 3, 1, fl, g, s0, s1, c, np);
    chk("a_rdy", 64'(a_rdy), 64'(g[2:0]));
    chk("a_ptr", 64'(a_ptr), 64'(ptr_a));
    e.wr   = (c > 0) ? 2'b01 : 2'b00;
    e.tag  = (c > 0) ? 8'(a_tag[s0*4 +: 4]) : 8'h0;
    e.data = (c > 0) ? 64'(a_wdata[s0*32 +: 32]) : 64'h0;
    qa.push_back(e);
    @(posedge clk);
    #1;
    if (qa.size() == 0) begin
      chk("a_queue", 64'(0), 64'(1));
    end else begin
      e = qa.pop_front();
      chk("a_wr", 64'(a_wr), 64'(e.wr[0]));
      chk("a_tag", 64'(a_ctag), 64'(e.tag[3:0]));
      chk("a_data", 64'(a_cdata), 64'(e.data[31:0]));
    end
`ifdef CDB_RR_EN
    ptr_a = np;
`endif
  endtask

  task automatic step_b(input logic [3:0] req, input logic fl);
    logic [3:0] g;
    int s0, s1, c, np;
    exp_t e;
    b_req = req;
    b_flush = fl;
    for (int i = 0; i < 4; i++) begin
      b_tag[i*4 +: 4]    = 4'($urandom);
      b_wdata[i*32 +: 32] = $urandom;
    end
    #1;
    model(req, ptr_b, 4, 2, fl, g, s0, s1, c, np);
    chk("b_rdy", 64'(b_rdy), 64'(g));
    chk("b_ptr", 64'(b_ptr), 64'(ptr_b));
    e.wr = '0; e.tag = '0; e.data = '0;
    if (c > 0) begin
      e.wr[0] = 1'b1;
      e.tag[3:0] = b_tag[s0*4 +: 4];
      e.data[31:0] = b_wdata[s0*32 +: 32];
    end
    if (c > 1) begin
      e.wr[1] = 1'b1;
      e.tag[7:4] = b_tag[s1*4 +: 4];
      e.data[63:32] = b_wdata[s1*32 +: 32];
    end
    qb.push_back(e);
    @(posedge clk);
    #1;
    if (qb.size() == 0) begin
      chk("b_queue", 64'(0), 64'(1));
    end else begin
      e = qb.pop_front();
      chk("b_wr", 64'(b_wr), 64'(e.wr));
      chk("b_tag", 64'(b_ctag), 64'(e.tag));
      chk("b_data", 64'(b_cdata), e.data);
    end
`ifdef CDB_RR_EN
    ptr_b = np;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 3'b111; a_flush = 1'b0; a_tag = '0; a_wdata = '0;
    b_req = '0;     b_flush = 1'b0; b_tag = '0; b_wdata = '0;

    // Reset held with all sources requesting.
    #12;
    chk("rst_a_rdy", 64'(a_rdy), 64'(0));
    chk("rst_a_wr", 64'(a_wr), 64'(0));
    chk("rst_a_tag", 64'(a_ctag), 64'(0));
    chk("rst_a_ptr", 64'(a_ptr), 64'(0));
    chk("rst_b_wr", 64'(b_wr), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Release, then continuous requests rotate the grant.
    for (int i = 0; i < 7; i++) step_a(3'b111, 1'b0);
    // Idle lanes, pointer holds.
    step_a(3'b000, 1'b0);
    step_a(3'b000, 1'b0);
    // Flush squashes a pending request; src1 then src2 afterward.
    step_a(3'b110, 1'b1);
    step_a(3'b110, 1'b0);
    step_a(3'b110, 1'b0);
    step_a(3'b101, 1'b0);
    step_a(3'b111, 1'b0);

    // Reset arriving mid-broadcast clears lanes without a clock edge.
    chk("mid_a_wr_live", 64'(a_wr), 64'(1));
    a_req = 3'b000;
    rst_n = 1'b0;
    #1;
    chk("mid_a_wr", 64'(a_wr), 64'(0));
    chk("mid_a_tag", 64'(a_ctag), 64'(0));
    chk("mid_a_data", 64'(a_cdata), 64'(0));
    chk("mid_a_ptr", 64'(a_ptr), 64'(0));
    ptr_a = 0;
    ptr_b = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two lanes: move pointer to 3, then wrap-around fill.
    step_b(4'b0100, 1'b0);
    step_b(4'b1011, 1'b0);
    for (int i = 0; i < 3; i++) step_b(4'b1111, 1'b0);
    step_b(4'b0000, 1'b0);
    step_b(4'b1111, 1'b1);
    step_b(4'b0001, 1'b0);
    step_b(4'b1000, 1'b0);
    step_b(4'b0110, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
